branch_resolve_unit: RTL and testbench

- Parametrised successor to the single Branch/Zero AND gate that drives pc_src.
- Holds a registered condition-flag set (Z, N, C, V) and evaluates eight branch conditions.
- Flags written in the same cycle are forwarded to the evaluation.
- Sequences a post-branch flush window, with an optional taken-branch counter; sits between ALU flag outputs, control unit and PC mux.

---
 rtl/branch_resolve_unit.sv | 112 +++++++++++
 tb/tb_branch_resolve_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: registered Z/N/C/V flags with same-cycle forwarding, eight-way
// condition evaluation and a post-branch flush sequencer. Optional taken counter: BRANCH_STATS_EN.
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             branch,
    input  logic [2:0]       cond,
    input  logic             flag_we,
    input  logic             zero_in,
    input  logic             neg_in,
    input  logic             carry_in,
    input  logic             ovf_in,
    output logic             pc_src,
    output logic             flush,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Counter is preloaded with FLUSH_CYCLES-1 so the window spans exactly FLUSH_CYCLES cycles.
    localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

    state_t     state_q;
    logic [3:0] flush_cnt_q;
    logic [3:0] eff_flags;
    logic       cond_true;
    logic       taken;

    assign eff_flags = flag_we ? {zero_in, neg_in, carry_in, ovf_in} : flags_q;

    // eff_flags = {Z, N, C, V}
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'b000:  cond_true = 1'b0;
            3'b001:  cond_true = eff_flags[3];
            3'b010:  cond_true = ~eff_flags[3];
            3'b011:  cond_true = eff_flags[2] ^ eff_flags[0];
            3'b100:  cond_true = ~(eff_flags[2] ^ eff_flags[0]);
            3'b101:  cond_true = ~eff_flags[1];
            3'b110:  cond_true = eff_flags[1];
            3'b111:  cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign taken  = rst_n & branch & cond_true & ~flush;
    assign pc_src = taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if (flag_we) begin
            flags_q <= {zero_in, neg_in, carry_in, ovf_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            flush_cnt_q <= 4'd0;
            flush       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (taken && (FLUSH_CYCLES > 0)) begin
                        state_q     <= FLUSH;
                        flush_cnt_q <= FLUSH_LOAD;
                        flush       <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_q == 4'd0) begin
                        state_q <= IDLE;
                        flush   <= 1'b0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    flush   <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating: holds at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (taken && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign taken_cnt = cnt_q;
`else
    assign taken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: default build, FLUSH_CYCLES=0 build and CNT_W=2 build
// share one stimulus stream; each test task checks the instance it targets.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst_n;
    logic        branch;
    logic [2:0]  cond;
    logic        flag_we;
    logic        zero_in;
    logic        neg_in;
    logic        carry_in;
    logic        ovf_in;

    logic        pc_src_a, flush_a;
    logic [3:0]  flags_a;
    logic [15:0] cnt_a;

    logic        pc_src_z, flush_z;
    logic [3:0]  flags_z;
    logic [15:0] cnt_z;

    logic        pc_src_c, flush_c;
    logic [3:0]  flags_c;
    logic [1:0]  cnt_c;

    int total;
    int bad;

    branch_resolve_unit #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .branch(branch), .cond(cond), .flag_we(flag_we),
        .zero_in(zero_in), .neg_in(neg_in), .carry_in(carry_in), .ovf_in(ovf_in),
        .pc_src(pc_src_a), .flush(flush_a), .flags_q(flags_a), .taken_cnt(cnt_a)
    );

    branch_resolve_unit #(.FLUSH_CYCLES(0), .CNT_W(16)) dut_nf (
        .clk(clk), .rst_n(rst_n), .branch(branch), .cond(cond), .flag_we(flag_we),
        .zero_in(zero_in), .neg_in(neg_in), .carry_in(carry_in), .ovf_in(ovf_in),
        .pc_src(pc_src_z), .flush(flush_z), .flags_q(flags_z), .taken_cnt(cnt_z)
    );

    branch_resolve_unit #(.FLUSH_CYCLES(2), .CNT_W(2)) dut_cnt (
        .clk(clk), .rst_n(rst_n), .branch(branch), .cond(cond), .flag_we(flag_we),
        .zero_in(zero_in), .neg_in(neg_in), .carry_in(carry_in), .ovf_in(ovf_in),
        .pc_src(pc_src_c), .flush(flush_c), .flags_q(flags_c), .taken_cnt(cnt_c)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; checks happen 1 time unit later.
    task automatic drive(input logic b, input logic [2:0] c, input logic we, input logic [3:0] f);
        @(negedge clk);
        branch  = b;
        cond    = c;
        flag_we = we;
        {zero_in, neg_in, carry_in, ovf_in} = f;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        branch  = 1'b0;
        cond    = 3'b000;
        flag_we = 1'b0;
        {zero_in, neg_in, carry_in, ovf_in} = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        branch  = 1'b1;
        cond    = 3'b111;
        flag_we = 1'b1;
        {zero_in, neg_in, carry_in, ovf_in} = 4'b1111;
        @(posedge clk);
        #1;
        total++; if (pc_src_a !== 1'b0) begin bad++; $display("FAIL rst_pc_src got=%b exp=0", pc_src_a); end
        total++; if (flush_a !== 1'b0) begin bad++; $display("FAIL rst_flush got=%b exp=0", flush_a); end
        total++; if (flags_a !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b exp=0000", flags_a); end
        total++; if (cnt_a !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", cnt_a); end
        total++; if (cnt_c !== 2'd0) begin bad++; $display("FAIL rst_cnt_c got=%0d exp=0", cnt_c); end
        do_reset();
    endtask

    task automatic test_forward();
        do_reset();
        drive(1'b1, 3'b001, 1'b1, 4'b1000);
        total++; if (pc_src_a !== 1'b1) begin bad++; $display("FAIL fwd_pc_src got=%b exp=1", pc_src_a); end
        drive(1'b0, 3'b000, 1'b0, 4'b0000);
        total++; if (flags_a !== 4'b1000) begin bad++; $display("FAIL fwd_flags got=%b exp=1000", flags_a); end
        total++; if (flush_a !== 1'b1) begin bad++; $display("FAIL fwd_flush1 got=%b exp=1", flush_a); end
        drive(1'b0, 3'b000, 1'b0, 4'b0000);
        total++; if (flush_a !== 1'b1) begin bad++; $display("FAIL fwd_flush2 got=%b exp=1", flush_a); end
        drive(1'b0, 3'b000, 1'b0, 4'b0000);
        total++; if (flush_a !== 1'b0) begin bad++; $display("FAIL fwd_flush3 got=%b exp=0", flush_a); end
    endtask

    task automatic test_conditions();
        logic [7:0] exp_reg;
        logic [7:0] exp_fwd;
        exp_reg = 8'hAC;  // Z=0 N=1 C=0 V=0
        exp_fwd = 8'hCA;  // Z=1 N=0 C=1 V=1
        do_reset();
        drive(1'b0, 3'b000, 1'b1, 4'b0100);
        drive(1'b0, 3'b000, 1'b0, 4'b0000);
        total++; if (flags_a !== 4'b0100) begin bad++; $display("FAIL cond_flags got=%b exp=0100", flags_a); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 1'b0, 4'b0000);
            total++;
            if (pc_src_a !== exp_reg[i]) begin
                bad++; $display("FAIL cond_reg_%0d got=%b exp=%b", i, pc_src_a, exp_reg[i]);
            end
            repeat (3) drive(1'b0, 3'b000, 1'b0, 4'b0000);
        end
        // Registered flags stay 0100 while the branch cycle forwards 1011.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 1'b1, 4'b1011);
            total++;
            if (pc_src_a !== exp_fwd[i]) begin
                bad++; $display("FAIL cond_fwd_%0d got=%b exp=%b", i, pc_src_a, exp_fwd[i]);
            end
            repeat (3) drive(1'b0, 3'b000, 1'b1, 4'b0100);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 3'b111, 1'b0, 4'b0000);
        total++; if (pc_src_a !== 1'b1) begin bad++; $display("FAIL b2b_first got=%b exp=1", pc_src_a); end
        drive(1'b1, 3'b111, 1'b1, 4'b0110);
        total++; if (flush_a !== 1'b1) begin bad++; $display("FAIL b2b_flush1 got=%b exp=1", flush_a); end
        total++; if (pc_src_a !== 1'b0) begin bad++; $display("FAIL b2b_blocked1 got=%b exp=0", pc_src_a); end
        drive(1'b1, 3'b111, 1'b0, 4'b0000);
        total++; if (flush_a !== 1'b1) begin bad++; $display("FAIL b2b_flush2 got=%b exp=1", flush_a); end
        total++; if (pc_src_a !== 1'b0) begin bad++; $display("FAIL b2b_blocked2 got=%b exp=0", pc_src_a); end
        total++; if (flags_a !== 4'b0110) begin bad++; $display("FAIL b2b_flags got=%b exp=0110", flags_a); end
        drive(1'b0, 3'b000, 1'b0, 4'b0000);
        total++; if (flush_a !== 1'b0) begin bad++; $display("FAIL b2b_no_ext got=%b exp=0", flush_a); end
        drive(1'b0, 3'b000, 1'b0, 4'b0000);
        total++; if (flush_a !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", flush_a); end
    endtask

    task automatic test_zero_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b111, 1'b0, 4'b0000);
            total++; if (pc_src_z !== 1'b1) begin bad++; $display("FAIL nf_pc_src_%0d got=%b exp=1", i, pc_src_z); end
            total++; if (flush_z !== 1'b0) begin bad++; $display("FAIL nf_flush_%0d got=%b exp=0", i, flush_z); end
        end
        drive(1'b0, 3'b000, 1'b0, 4'b0000);
        total++; if (flush_z !== 1'b0) begin bad++; $display("FAIL nf_flush_end got=%b exp=0", flush_z); end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        drive(1'b1, 3'b111, 1'b1, 4'b1100);
        drive(1'b0, 3'b000, 1'b0, 4'b0000);
        total++; if (flush_a !== 1'b1) begin bad++; $display("FAIL mid_flush_pre got=%b exp=1", flush_a); end
        total++; if (flags_a !== 4'b1100) begin bad++; $display("FAIL mid_flags_pre got=%b exp=1100", flags_a); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (flush_a !== 1'b0) begin bad++; $display("FAIL mid_flush_async got=%b exp=0", flush_a); end
        total++; if (flags_a !== 4'b0000) begin bad++; $display("FAIL mid_flags_async got=%b exp=0000", flags_a); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 3'b001, 1'b0, 4'b0000);
        total++; if (pc_src_a !== 1'b0) begin bad++; $display("FAIL mid_eq_after got=%b exp=0", pc_src_a); end
        drive(1'b0, 3'b000, 1'b0, 4'b0000);
        total++; if (flush_a !== 1'b0) begin bad++; $display("FAIL mid_flush_after got=%b exp=0", flush_a); end
    endtask

    task automatic test_stats();
        logic [1:0] exp_cnt;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 3'b111, 1'b0, 4'b0000);
            total++; if (pc_src_c !== 1'b1) begin bad++; $display("FAIL stat_pc_src_%0d got=%b exp=1", k, pc_src_c); end
            drive(1'b0, 3'b000, 1'b0, 4'b0000);
`ifdef BRANCH_STATS_EN
            exp_cnt = (k > 3) ? 2'd3 : 2'(k);
`else
            exp_cnt = 2'd0;
`endif
            total++; if (cnt_c !== exp_cnt) begin bad++; $display("FAIL stat_cnt_%0d got=%0d exp=%0d", k, cnt_c, exp_cnt); end
            repeat (2) drive(1'b0, 3'b000, 1'b0, 4'b0000);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        branch  = 1'b0;
        cond    = 3'b000;
        flag_we = 1'b0;
        {zero_in, neg_in, carry_in, ovf_in} = 4'b0000;
        test_reset();
        test_forward();
        test_conditions();
        test_back_to_back();
        test_zero_flush();
        test_reset_mid_flush();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
